light_sep_stream: RTL and testbench

Parametrised multi-channel light separator with an APB control/status slave. It accepts a pixel stream of `Channels` parallel components, compares each component against a per-channel APB-programmed threshold, and emits a masked/binarised/inverted stream. It also counts "light" pixels per channel over a programmed frame length. It sits behind the system APB bus between the image source and downstream pixel consumers.

---
 rtl/light_sep_stream_if.sv | 32 +++
 rtl/light_sep_stream.sv | 199 +++++++++++++++++++
 tb/tb_light_sep_stream.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/light_sep_stream_if.sv
// Bundles the APB control/status port and the pixel in/out stream of light_sep_stream.
// Latency: none; this file only declares the wiring.
// Backpressure: none; PREADY is tied high and the pixel stream cannot be stalled.
interface light_sep_stream_if #(
    parameter int Amba_Word       = 32,
    parameter int Amba_Addr_Depth = 8,
    parameter int PixelPrecision  = 8,
    parameter int Channels        = 3
);
    logic                               PSEL;
    logic                               PENABLE;
    logic                               PWRITE;
    logic [Amba_Addr_Depth-1:0]         PADDR;
    logic [Amba_Word-1:0]               PWDATA;
    logic [Amba_Word-1:0]               PRDATA;
    logic                               PREADY;
    logic [Channels*PixelPrecision-1:0] ImInput;
    logic                               ImValid;
    logic [Channels*PixelPrecision-1:0] ImOutput;
    logic                               ImOutValid;
    logic                               FrameDone;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, ImInput, ImValid,
        input  PRDATA, PREADY, ImOutput, ImOutValid, FrameDone
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, ImInput, ImValid,
        output PRDATA, PREADY, ImOutput, ImOutValid, FrameDone
    );
endinterface

// File: rtl/light_sep_stream.sv
// Per-channel threshold light separator with APB registers and per-frame light counters.
// Latency: ImValid to ImOutValid is 2 cycles (compare stage, output stage); APB has no wait states.
// Backpressure: none; one pixel per cycle is accepted while in RUN, pixels outside RUN are dropped.
module light_sep_stream #(
    parameter int Amba_Word       = 32,
    parameter int Amba_Addr_Depth = 8,
    parameter int PixelPrecision  = 8,
    parameter int Channels        = 3
) (
    input  logic               clk,
    input  logic               rst,
    light_sep_stream_if.slave  bus
);
    localparam int PP = PixelPrecision;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [Amba_Word-1:0] CNT_MAX = '1;
    localparam logic [Amba_Word-1:0] CNT_ONE = {{(Amba_Word-1){1'b0}}, 1'b1};

    logic [1:0]              state;
    logic [1:0]              mode;
    logic [1:0]              sh_mode;
    logic [Amba_Word-1:0]    frame_len;
    logic [Amba_Word-1:0]    pix_cnt;
    logic [Amba_Word-1:0]    thresh    [Channels];
    logic [Amba_Word-1:0]    light_cnt [Channels];
    logic [PP-1:0]           sh_thresh [Channels];
    logic                    done;

    logic [31:0]             widx;
    logic                    wr_en, rd_en, wr_ctrl, wr_status;
    logic                    start, abort, done_clr;
    logic [1:0]              mode_nxt;
    logic                    accept;
    logic [Channels-1:0]     light_now;
    logic [Amba_Word-1:0]    pix_nxt;
    logic [Amba_Word-1:0]    rdata;
    logic                    unused_addr;

    logic                    s1_vld;
    logic [Channels*PP-1:0]  s1_pix;
    logic [Channels-1:0]     s1_light;
    logic [1:0]              s1_mode;
    logic [Channels*PP-1:0]  out_nxt;

    // Word index of the register; the two byte-lane bits carry no meaning.
    assign widx        = 32'(bus.PADDR[Amba_Addr_Depth-1:2]);
    assign unused_addr = ^bus.PADDR[1:0];

    assign wr_en     = bus.PSEL & bus.PENABLE & bus.PWRITE;
    assign rd_en     = bus.PSEL & bus.PENABLE & ~bus.PWRITE;
    assign wr_ctrl   = wr_en && (widx == 32'd0);
    assign wr_status = wr_en && (widx == 32'd2);
    assign start     = wr_ctrl & bus.PWDATA[0];
    assign abort     = wr_ctrl & bus.PWDATA[3];
    assign done_clr  = wr_status & bus.PWDATA[1];
    // A CTRL write that carries start also carries the mode the frame should use.
    assign mode_nxt  = wr_ctrl ? bus.PWDATA[2:1] : mode;
    assign accept    = (state == ST_RUN) && bus.ImValid && !abort;
    assign pix_nxt   = (pix_cnt == CNT_MAX) ? pix_cnt : pix_cnt + CNT_ONE;

    // Per-channel light decision against the thresholds frozen at start.
    always_comb begin
        light_now = '0;
        for (int c = 0; c < Channels; c++) begin
            light_now[c] = bus.ImInput[c*PP +: PP] >= sh_thresh[c];
        end
    end

    // Software-writable configuration registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode      <= '0;
            frame_len <= '0;
            for (int c = 0; c < Channels; c++) thresh[c] <= '0;
        end else if (wr_en) begin
            if (widx == 32'd0) mode <= bus.PWDATA[2:1];
            if (widx == 32'd1) frame_len <= bus.PWDATA;
            for (int c = 0; c < Channels; c++) begin
                if (widx == 32'(4 + c)) thresh[c] <= bus.PWDATA;
            end
        end
    end

    // Frame FSM, shadow configuration, saturating pixel/light counters and done flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            done    <= 1'b0;
            pix_cnt <= '0;
            sh_mode <= '0;
            for (int c = 0; c < Channels; c++) begin
                light_cnt[c] <= '0;
                sh_thresh[c] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && !abort) begin
                        sh_mode <= mode_nxt;
                        pix_cnt <= '0;
                        for (int c = 0; c < Channels; c++) begin
                            sh_thresh[c] <= thresh[c][PP-1:0];
                            light_cnt[c] <= '0;
                        end
                        if (frame_len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            done  <= 1'b0;
                        end
                    end else if (state == ST_DONE && done_clr) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (accept) begin
                        pix_cnt <= pix_nxt;
                        for (int c = 0; c < Channels; c++) begin
                            if (light_now[c] && light_cnt[c] != CNT_MAX)
                                light_cnt[c] <= light_cnt[c] + CNT_ONE;
                        end
                        if (pix_nxt == frame_len) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage 1: capture the accepted pixel, its light mask and the frame's mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld   <= 1'b0;
            s1_pix   <= '0;
            s1_light <= '0;
            s1_mode  <= '0;
        end else begin
            s1_vld   <= accept;
            s1_pix   <= bus.ImInput;
            s1_light <= light_now;
            s1_mode  <= sh_mode;
        end
    end

    // Apply the selected mask/binarise/invert function per component.
    always_comb begin
        out_nxt = '0;
        for (int c = 0; c < Channels; c++) begin
            case (s1_mode)
                2'd0:    out_nxt[c*PP +: PP] = s1_pix[c*PP +: PP] & {PP{s1_light[c]}};
                2'd1:    out_nxt[c*PP +: PP] = {PP{s1_light[c]}};
                2'd2:    out_nxt[c*PP +: PP] = ~s1_pix[c*PP +: PP] & {PP{~s1_light[c]}};
                default: out_nxt[c*PP +: PP] = s1_pix[c*PP +: PP];
            endcase
        end
    end

    // Stage 2: registered output, forced to zero when no pixel is valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ImOutValid <= 1'b0;
            bus.ImOutput   <= '0;
        end else begin
            bus.ImOutValid <= s1_vld;
            bus.ImOutput   <= s1_vld ? out_nxt : '0;
        end
    end

    // APB read mux: live register value during a read access phase, zero otherwise.
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (widx)
                32'd0:   rdata = {{(Amba_Word-3){1'b0}}, mode, 1'b0};
                32'd1:   rdata = frame_len;
                32'd2:   rdata = {{(Amba_Word-2){1'b0}}, done, state == ST_RUN};
                32'd3:   rdata = pix_cnt;
                default: rdata = '0;
            endcase
            for (int c = 0; c < Channels; c++) begin
                if (widx == 32'(4 + c))  rdata = thresh[c];
                if (widx == 32'(16 + c)) rdata = light_cnt[c];
            end
        end
    end

    assign bus.PRDATA    = rdata;
    assign bus.PREADY    = 1'b1;
    assign bus.FrameDone = done;
endmodule

// File: tb/tb_light_sep_stream.sv
// Self-checking bench for light_sep_stream: vector table per mode plus scoreboarded output stream.
// Latency: outputs are expected exactly 2 cycles after the driven pixel.
// Backpressure: none; the bench streams pixels back to back.
module tb_light_sep_stream;
    localparam int AW = 32;
    localparam int AD = 8;
    localparam int PP = 8;
    localparam int CH = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    light_sep_stream_if #(.Amba_Word(AW), .Amba_Addr_Depth(AD),
                          .PixelPrecision(PP), .Channels(CH)) bus ();

    light_sep_stream #(.Amba_Word(AW), .Amba_Addr_Depth(AD),
                       .PixelPrecision(PP), .Channels(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CH*PP-1:0] dat;
        int               cyc;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [1:0]       mode;
        logic [CH*PP-1:0] pix;
        logic [CH*PP-1:0] exp;
    } vec_t;
    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [CH*PP-1:0] pk(input int a, input int b, input int c);
        logic [7:0] x, y, z;
        x = a[7:0];
        y = b[7:0];
        z = c[7:0];
        return {z, y, x};
    endfunction

    // Output monitor: every valid output must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (bus.ImOutValid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_outvalid", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("out_dat", 32'(bus.ImOutput), 32'(e.dat));
                chk("out_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        @(negedge clk);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        #1 d = bus.PRDATA;
        @(negedge clk);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        chk(name, d, exp);
    endtask

    // Streams n pixels of table row block m back to back and scoreboards each expected output.
    task automatic send_pixels(input int m, input int n);
        sb_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.ImValid = 1'b1;
            bus.ImInput = vecs[m*4+i].pix;
            e.dat = vecs[m*4+i].exp;
            e.cyc = cyc + 2;
            sbq.push_back(e);
        end
        @(negedge clk);
        bus.ImValid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] zaddr [14];
        int         lc_exp [3];
        logic [31:0] d;

        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0; bus.ImInput = '0; bus.ImValid = 1'b0;

        // Thresholds {100, 50, 200}; light patterns: P1 L D L, P2 D L D, P3 L D D, P4 L D L.
        vecs[0]  = '{2'd0, pk(120, 40, 250), pk(120,   0, 250)};
        vecs[1]  = '{2'd0, pk( 99, 50, 199), pk(  0,  50,   0)};
        vecs[2]  = '{2'd0, pk(255,  0,   0), pk(255,   0,   0)};
        vecs[3]  = '{2'd0, pk(100, 49, 200), pk(100,   0, 200)};
        vecs[4]  = '{2'd1, pk(120, 40, 250), pk(255,   0, 255)};
        vecs[5]  = '{2'd1, pk( 99, 50, 199), pk(  0, 255,   0)};
        vecs[6]  = '{2'd1, pk(255,  0,   0), pk(255,   0,   0)};
        vecs[7]  = '{2'd1, pk(100, 49, 200), pk(255,   0, 255)};
        vecs[8]  = '{2'd2, pk(120, 40, 250), pk(  0, 215,   0)};
        vecs[9]  = '{2'd2, pk( 99, 50, 199), pk(156,   0,  56)};
        vecs[10] = '{2'd2, pk(255,  0,   0), pk(  0, 255, 255)};
        vecs[11] = '{2'd2, pk(100, 49, 200), pk(  0, 206,   0)};
        vecs[12] = '{2'd3, pk(120, 40, 250), pk(120,  40, 250)};
        vecs[13] = '{2'd3, pk( 99, 50, 199), pk( 99,  50, 199)};
        vecs[14] = '{2'd3, pk(255,  0,   0), pk(255,   0,   0)};
        vecs[15] = '{2'd3, pk(100, 49, 200), pk(100,  49, 200)};
        lc_exp = '{3, 1, 2};
        zaddr = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                  8'h40, 8'h44, 8'h48, 8'h20, 8'h4C, 8'h80};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_outvalid", 32'(bus.ImOutValid), 32'd0);
        chk("rst_output", 32'(bus.ImOutput), 32'd0);
        chk("rst_prdata", bus.PRDATA, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("pready", 32'(bus.PREADY), 32'd1);
        chk("framedone_reset", 32'(bus.FrameDone), 32'd0);
        for (int i = 0; i < 14; i++) chk_reg($sformatf("reset_reg_%0h", zaddr[i]), zaddr[i], 32'd0);

        // Configuration and readback, including a channel beyond Channels.
        apb_write(8'h04, 32'd4);
        apb_write(8'h10, 32'd100);
        apb_write(8'h14, 32'd50);
        apb_write(8'h18, 32'd200);
        apb_write(8'h1C, 32'd77);
        chk_reg("thresh1", 8'h15, 32'd50);
        chk_reg("thresh3_unmapped", 8'h1C, 32'd0);
        chk_reg("frame_len", 8'h04, 32'd4);

        // PRDATA stays 0 during a setup phase.
        @(negedge clk);
        bus.PSEL = 1'b1; bus.PADDR = 8'h04; bus.PWRITE = 1'b0;
        #1 chk("prdata_setup_phase", bus.PRDATA, 32'd0);
        @(negedge clk);
        bus.PSEL = 1'b0;

        // One frame per mode, driven from the vector table.
        for (int m = 0; m < 4; m++) begin
            apb_write(8'h00, 32'((m << 1) | 1));
            chk_reg($sformatf("status_busy_m%0d", m), 8'h08, 32'd1);
            send_pixels(m, 4);
            chk($sformatf("framedone_edge_m%0d", m), 32'(bus.FrameDone), 32'd1);
            drain();
            chk_reg($sformatf("status_done_m%0d", m), 8'h08, 32'd2);
            chk_reg($sformatf("pix_cnt_m%0d", m), 8'h0C, 32'd4);
            for (int c = 0; c < CH; c++)
                chk_reg($sformatf("light_cnt%0d_m%0d", c, m), 8'(64 + 4*c), 32'(lc_exp[c]));
            chk_reg($sformatf("ctrl_mode_m%0d", m), 8'h00, 32'(m << 1));
            apb_write(8'h08, 32'd2);
            chk_reg($sformatf("status_cleared_m%0d", m), 8'h08, 32'd0);
        end

        // Abort after two pixels.
        apb_write(8'h00, 32'd1);
        send_pixels(0, 2);
        apb_write(8'h00, 32'd8);
        drain();
        chk_reg("abort_status", 8'h08, 32'd0);
        chk_reg("abort_pix_cnt", 8'h0C, 32'd2);
        chk_reg("abort_light0", 8'h40, 32'd1);
        chk_reg("abort_light1", 8'h44, 32'd1);
        chk("abort_framedone", 32'(bus.FrameDone), 32'd0);
        // Pixels offered in IDLE are dropped.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.ImValid = (i < 3);
            bus.ImInput = vecs[0].pix;
            chk("idle_no_outvalid", 32'(bus.ImOutValid), 32'd0);
        end
        chk_reg("idle_pix_cnt_held", 8'h0C, 32'd2);
        // Start together with abort in IDLE: abort wins, nothing happens.
        apb_write(8'h00, 32'd9);
        chk_reg("start_abort_idle", 8'h08, 32'd0);
        // Fresh start clears the held counts.
        apb_write(8'h00, 32'd1);
        chk_reg("restart_status", 8'h08, 32'd1);
        chk_reg("restart_pix_cnt", 8'h0C, 32'd0);
        chk_reg("restart_light0", 8'h40, 32'd0);
        apb_write(8'h00, 32'd8);

        // Zero-length frame goes straight to DONE.
        apb_write(8'h04, 32'd0);
        apb_write(8'h00, 32'd1);
        chk("len0_framedone", 32'(bus.FrameDone), 32'd1);
        chk_reg("len0_status", 8'h08, 32'd2);
        chk_reg("len0_pix_cnt", 8'h0C, 32'd0);
        for (int c = 0; c < CH; c++)
            chk_reg($sformatf("len0_light%0d", c), 8'(64 + 4*c), 32'd0);
        apb_write(8'h08, 32'd2);
        chk_reg("len0_status_cleared", 8'h08, 32'd0);
        chk("len0_framedone_cleared", 32'(bus.FrameDone), 32'd0);

        // Asynchronous reset in the middle of a frame.
        apb_write(8'h04, 32'd4);
        apb_write(8'h00, 32'd1);
        send_pixels(0, 2);
        bus.ImValid = 1'b1;
        #2 rst = 1'b0;
        sbq.delete();
        #1;
        chk("midrst_outvalid", 32'(bus.ImOutValid), 32'd0);
        chk("midrst_output", 32'(bus.ImOutput), 32'd0);
        chk("midrst_framedone", 32'(bus.FrameDone), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_no_outvalid", 32'(bus.ImOutValid), 32'd0);
        end
        bus.ImValid = 1'b0;
        chk_reg("postrst_status", 8'h08, 32'd0);
        chk_reg("postrst_pix_cnt", 8'h0C, 32'd0);
        chk_reg("postrst_thresh0", 8'h10, 32'd0);
        apb_read(8'h04, d);
        chk("postrst_frame_len", d, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
